cache_ctrl: RTL and testbench
=============================

Name: cache_ctrl

Overview:
- Sequencing FSM for the 4-way set-associative L1 tag/compare datapath.
- Accepts one processing-element (PE) read/write request at a time and drives the compare stage's access strobe.
- On a hit: updates LRU, mod and data enables. On a miss: runs dirty-victim writeback, then fill, then replays the lookup.
- Sits between the PE port, the tag/val/mod/lru/data arrays plus compare logic, and the next-level memory port.

Parameters:
- ADDR_W, 32, PE byte address width.
- DATA_W, 32, PE write data width.
- CNT_W, 16, width of performance counters (optional feature only).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- pe_req  in  1  PE request valid.
- pe_we  in  1  1 = write, 0 = read.
- pe_addr  in  ADDR_W  request address.
- pe_wdata  in  DATA_W  write data.
- pe_ready  out  1  controller can accept a request.
- pe_rsp_valid  out  1  one-cycle completion pulse.
- req_addr  out  ADDR_W  latched request address; drives array index/tag.
- req_wdata  out  DATA_W  latched write data.
- pe_access  out  1  drives the compare stage access/qualify input.
- way_hit  in  4  one-hot hit vector from compare.
- fill_or_victim_way  in  4  one-hot victim/fill way from compare.
- victim_dirty  in  1  mod bit of fill_or_victim_way.
- tag_we  out  4  per-way tag write enable.
- data_we  out  4  per-way data write enable.
- val_set  out  1  set valid bit of the way in tag_we.
- mod_set  out  1  set mod bit of the way in data_we.
- mod_clr  out  1  clear mod bit of the way in tag_we.
- lru_we  out  1  LRU update strobe.
- lru_way  out  4  way to mark MRU.
- mem_req  out  1  next-level request, held until acknowledged.
- mem_we  out  1  1 = writeback, 0 = fill.
- mem_way  out  4  way being written back or filled.
- mem_ack  in  1  next-level completion.
- ctrl_err  out  1  sticky protocol error flag.

Behaviour:
- States: IDLE, LOOKUP, WB, FILL, RESP.
- Reset (async, reset_n=0): state=IDLE; every output 0 except pe_ready=1; latches, victim register and ctrl_err cleared. Reset mid-transaction abandons it and drops mem_req immediately; no response is issued.
- IDLE:
  - pe_ready=1.
  - pe_req=1 latches pe_we/pe_addr/pe_wdata and moves to LOOKUP.
  - pe_req while not IDLE is ignored (pe_ready=0).
- LOOKUP (exactly 1 cycle, pe_access=1):
  - Hit (|way_hit): lru_we=1, lru_way=way_hit. On a write, also data_we=way_hit and mod_set=1. Next state RESP.
  - Miss: register victim=fill_or_victim_way. Next state WB if victim_dirty=1, else FILL.
  - More than one way_hit bit set: ctrl_err<=1; use the lowest-index hit bit.
- WB:
  - mem_req=1, mem_we=1, mem_way=victim, held until mem_ack.
  - mem_ack in the first WB cycle is accepted.
  - On ack: go to FILL.
- FILL:
  - mem_req=1, mem_we=0, mem_way=victim, held until mem_ack.
  - On the ack cycle: tag_we=victim, data_we=victim, val_set=1, mod_clr=1. Next state LOOKUP (replay).
- Replay LOOKUP behaves as above, so a write merges and sets mod on the replay hit. A miss on replay sets ctrl_err, and the controller proceeds to RESP without refilling.
- RESP: pe_rsp_valid=1 for 1 cycle, then IDLE.
- Latency:
  - Hit: request accepted → rsp in 2 cycles (LOOKUP, RESP).
  - Clean miss: 3 + fill wait cycles.
  - Dirty miss: adds the writeback wait.
- mem_ack outside WB/FILL is ignored.
- Array enables are single-cycle pulses, all 0 in IDLE/RESP.
- victim stays stable from the miss cycle until the fill completes.

Optional Feature:
- Macro: CACHE_CTRL_PERF_CNT_EN.
- When defined, adds outputs hit_cnt, miss_cnt, wb_cnt (CNT_W each), reset to 0:
  - hit_cnt increments on a first-pass LOOKUP hit.
  - miss_cnt increments on a first-pass LOOKUP miss; replays never count.
  - wb_cnt increments on each WB ack.
  - All counters saturate at all-ones.
- When undefined, these ports and registers do not exist; behaviour is otherwise identical.

Test Plan:
- Read hit: way_hit=4'b0100 in LOOKUP → lru_we=1, lru_way=4'b0100 that cycle; pe_rsp_valid 2 cycles after accept; no mem_req.
- Write hit: pe_we=1, way_hit=4'b0001 → data_we=4'b0001 and mod_set=1 in LOOKUP; pe_rsp_valid next cycle.
- Clean miss: way_hit=0, fill_or_victim_way=4'b1000, victim_dirty=0, mem_ack after 3 cycles → mem_req/mem_we=0/mem_way=4'b1000 held 3 cycles; at ack tag_we=data_we=4'b1000, val_set=mod_clr=1; replay hit then rsp.
- Dirty miss: victim_dirty=1, victim 4'b0010, mem_ack 2 cycles into WB then 2 into FILL → WB with mem_we=1 precedes FILL; mem_way=4'b0010 throughout; wb_cnt=1 if CACHE_CTRL_PERF_CNT_EN.
- Reset mid-FILL: reset_n low while mem_req=1 → mem_req=0 asynchronously; pe_ready=1, no pe_rsp_valid after release.
- Error cases: way_hit=4'b0110 → ctrl_err=1 sticky and lru_way=4'b0010. Replay miss → ctrl_err=1 and response still issued.

Source files
------------

// File: rtl/cache_ctrl.sv
// ----------------------------------------------------------------------------
// cache_ctrl -- sequencing FSM for a 4-way set-associative L1 tag/compare
// datapath.
//
// Takes one processing-element (PE) request at a time. It latches the request,
// strobes the compare stage for one LOOKUP cycle and then does one of two
// things:
//   * on a hit, it updates LRU and, for a write, the data and mod bits;
//   * on a miss, it writes back a dirty victim, fills the victim way from the
//     next level, and replays the lookup.
// A one-cycle response pulse closes every transaction.
//
// Optional feature: define CACHE_CTRL_PERF_CNT_EN to add saturating
// hit/miss/writeback counters (hit_cnt, miss_cnt, wb_cnt).
//
// Ports
//   clk, reset_n          clock, asynchronous active-low reset
//   pe_req/pe_we          PE request valid / write flag
//   pe_addr/pe_wdata      PE request address / write data
//   pe_ready              controller idle, request can be accepted
//   pe_rsp_valid          one-cycle completion pulse
//   req_addr/req_wdata    latched request, drives array index/tag and data
//   pe_access             compare-stage qualify, high for each LOOKUP cycle
//   way_hit               one-hot hit vector from compare
//   fill_or_victim_way    one-hot victim/fill way from compare
//   victim_dirty          mod bit of fill_or_victim_way
//   tag_we/data_we        per-way tag/data write enables (single-cycle pulses)
//   val_set/mod_set/mod_clr  valid set, mod set, mod clear strobes
//   lru_we/lru_way        LRU update strobe and the way to mark MRU
//   mem_req/mem_we/mem_way   next-level request (held until mem_ack),
//                            1 = writeback, 0 = fill; way being moved
//   mem_ack               next-level completion
//   ctrl_err              sticky protocol error (multi-hit or replay miss)
//   hit_cnt/miss_cnt/wb_cnt  performance counters (optional feature only)
// ----------------------------------------------------------------------------
module cache_ctrl #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    // PE port
    input  logic              pe_req,
    input  logic              pe_we,
    input  logic [ADDR_W-1:0] pe_addr,
    input  logic [DATA_W-1:0] pe_wdata,
    output logic              pe_ready,
    output logic              pe_rsp_valid,
    // Array / compare port
    output logic [ADDR_W-1:0] req_addr,
    output logic [DATA_W-1:0] req_wdata,
    output logic              pe_access,
    input  logic [3:0]        way_hit,
    input  logic [3:0]        fill_or_victim_way,
    input  logic              victim_dirty,
    output logic [3:0]        tag_we,
    output logic [3:0]        data_we,
    output logic              val_set,
    output logic              mod_set,
    output logic              mod_clr,
    output logic              lru_we,
    output logic [3:0]        lru_way,
    // Next-level memory port
    output logic              mem_req,
    output logic              mem_we,
    output logic [3:0]        mem_way,
    input  logic              mem_ack,
`ifdef CACHE_CTRL_PERF_CNT_EN
    output logic [CNT_W-1:0]  hit_cnt,
    output logic [CNT_W-1:0]  miss_cnt,
    output logic [CNT_W-1:0]  wb_cnt,
`endif
    output logic              ctrl_err
);

    typedef enum logic [2:0] {
        StIdle,
        StLookup,
        StWb,
        StFill,
        StResp
    } state_e;

    state_e     state_q;
    logic       req_we_q;   // latched write flag
    logic       replay_q;   // current LOOKUP is the post-fill replay
    logic [3:0] victim_q;   // victim way, stable from miss until fill done

    logic       hit;
    logic       multi_hit;
    logic [3:0] hit_sel;
    logic       in_lookup;
    logic       fill_done;

    assign hit       = |way_hit;
    // Two's-complement trick isolates the lowest set bit of the hit vector.
    assign hit_sel   = way_hit & (~way_hit + 4'd1);
    // Clearing the lowest set bit leaves something only if two or more were set.
    assign multi_hit = (way_hit & (way_hit - 4'd1)) != 4'd0;
    assign in_lookup = (state_q == StLookup);
    assign fill_done = (state_q == StFill) && mem_ack;

    // ------------------------------------------------------------------------
    // Sequencing FSM. The outputs that depend only on state (pe_ready,
    // pe_access, pe_rsp_valid, mem_*) are registered alongside it, so each is
    // computed for the state being entered.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            req_we_q     <= 1'b0;
            replay_q     <= 1'b0;
            victim_q     <= 4'd0;
            req_addr     <= '0;
            req_wdata    <= '0;
            pe_ready     <= 1'b1;
            pe_rsp_valid <= 1'b0;
            pe_access    <= 1'b0;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_way      <= 4'd0;
            ctrl_err     <= 1'b0;
        end else begin
            pe_rsp_valid <= 1'b0;
            pe_access    <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (pe_req) begin
                        req_we_q  <= pe_we;
                        req_addr  <= pe_addr;
                        req_wdata <= pe_wdata;
                        replay_q  <= 1'b0;
                        pe_ready  <= 1'b0;
                        pe_access <= 1'b1;
                        state_q   <= StLookup;
                    end
                end

                StLookup: begin
                    if (hit) begin
                        if (multi_hit) begin
                            ctrl_err <= 1'b1;
                        end
                        replay_q     <= 1'b0;
                        pe_rsp_valid <= 1'b1;
                        state_q      <= StResp;
                    end else if (replay_q) begin
                        // The fill just installed this line, so a miss here
                        // means the arrays are inconsistent. Flag it and answer
                        // rather than loop.
                        ctrl_err     <= 1'b1;
                        replay_q     <= 1'b0;
                        pe_rsp_valid <= 1'b1;
                        state_q      <= StResp;
                    end else begin
                        victim_q <= fill_or_victim_way;
                        mem_way  <= fill_or_victim_way;
                        mem_req  <= 1'b1;
                        mem_we   <= victim_dirty;
                        state_q  <= victim_dirty ? StWb : StFill;
                    end
                end

                StWb: begin
                    if (mem_ack) begin
                        mem_we  <= 1'b0;
                        state_q <= StFill;
                    end
                end

                StFill: begin
                    if (mem_ack) begin
                        mem_req   <= 1'b0;
                        mem_way   <= 4'd0;
                        replay_q  <= 1'b1;
                        pe_access <= 1'b1;
                        state_q   <= StLookup;
                    end
                end

                StResp: begin
                    pe_ready <= 1'b1;
                    state_q  <= StIdle;
                end

                default: begin
                    mem_req  <= 1'b0;
                    mem_we   <= 1'b0;
                    mem_way  <= 4'd0;
                    replay_q <= 1'b0;
                    pe_ready <= 1'b1;
                    state_q  <= StIdle;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Array strobes. These depend on this cycle's compare result or on
    // mem_ack, so they are decoded combinationally from the current state.
    // Every strobe is a single-cycle pulse and is zero in IDLE/WB/RESP.
    // ------------------------------------------------------------------------
    always_comb begin
        lru_we  = 1'b0;
        lru_way = 4'd0;
        data_we = 4'd0;
        mod_set = 1'b0;
        tag_we  = 4'd0;
        val_set = 1'b0;
        mod_clr = 1'b0;

        if (in_lookup && hit) begin
            lru_we  = 1'b1;
            lru_way = hit_sel;
            if (req_we_q) begin
                data_we = hit_sel;
                mod_set = 1'b1;
            end
        end

        // The fill installs a clean, valid line in the victim way.
        if (fill_done) begin
            tag_we  = victim_q;
            data_we = victim_q;
            val_set = 1'b1;
            mod_clr = 1'b1;
        end
    end

`ifdef CACHE_CTRL_PERF_CNT_EN
    // ------------------------------------------------------------------------
    // Saturating performance counters. Replay lookups are not counted.
    // ------------------------------------------------------------------------
    logic first_lookup;
    assign first_lookup = in_lookup && !replay_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
            wb_cnt   <= '0;
        end else begin
            if (first_lookup && hit && (hit_cnt != '1)) begin
                hit_cnt <= hit_cnt + CNT_W'(1);
            end
            if (first_lookup && !hit && (miss_cnt != '1)) begin
                miss_cnt <= miss_cnt + CNT_W'(1);
            end
            if ((state_q == StWb) && mem_ack && (wb_cnt != '1)) begin
                wb_cnt <= wb_cnt + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_cache_ctrl.sv
// ----------------------------------------------------------------------------
// Testbench for cache_ctrl.
//
// Each transaction is expanded into a cycle-by-cycle table of stimulus and
// expected outputs. The table is built from the controller's transaction rules
// (accept, lookup, optional writeback, fill, replay, response). A single
// negedge process compares every DUT output against the table entry for the
// current cycle. Directed cases pin the expected latencies and strobes with
// literal values, and randomized transactions follow them.
// ----------------------------------------------------------------------------
module tb_cache_ctrl;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 16;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              pe_req = 1'b0;
    logic              pe_we = 1'b0;
    logic [ADDR_W-1:0] pe_addr = '0;
    logic [DATA_W-1:0] pe_wdata = '0;
    logic [3:0]        way_hit = '0;
    logic [3:0]        fill_or_victim_way = '0;
    logic              victim_dirty = 1'b0;
    logic              mem_ack = 1'b0;

    logic              pe_ready, pe_rsp_valid, pe_access;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [3:0]        tag_we, data_we, lru_way, mem_way;
    logic              val_set, mod_set, mod_clr, lru_we, mem_req, mem_we, ctrl_err;
`ifdef CACHE_CTRL_PERF_CNT_EN
    logic [CNT_W-1:0]  hit_cnt, miss_cnt, wb_cnt;
`endif

    cache_ctrl #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .pe_req             (pe_req),
        .pe_we              (pe_we),
        .pe_addr            (pe_addr),
        .pe_wdata           (pe_wdata),
        .pe_ready           (pe_ready),
        .pe_rsp_valid       (pe_rsp_valid),
        .req_addr           (req_addr),
        .req_wdata          (req_wdata),
        .pe_access          (pe_access),
        .way_hit            (way_hit),
        .fill_or_victim_way (fill_or_victim_way),
        .victim_dirty       (victim_dirty),
        .tag_we             (tag_we),
        .data_we            (data_we),
        .val_set            (val_set),
        .mod_set            (mod_set),
        .mod_clr            (mod_clr),
        .lru_we             (lru_we),
        .lru_way            (lru_way),
        .mem_req            (mem_req),
        .mem_we             (mem_we),
        .mem_way            (mem_way),
        .mem_ack            (mem_ack),
`ifdef CACHE_CTRL_PERF_CNT_EN
        .hit_cnt            (hit_cnt),
        .miss_cnt           (miss_cnt),
        .wb_cnt             (wb_cnt),
`endif
        .ctrl_err           (ctrl_err)
    );

    always #5 clk = ~clk;

    // One cycle of stimulus plus the outputs expected during that cycle.
    typedef struct packed {
        logic        req;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wh;
        logic [3:0]  fov;
        logic        dirty;
        logic        ack;
        logic        ready;
        logic        rsp;
        logic        access;
        logic        lru_we;
        logic        mod_set;
        logic        val_set;
        logic        mod_clr;
        logic        mreq;
        logic        mwe;
        logic        err;
        logic [3:0]  lru_way;
        logic [3:0]  tag_we;
        logic [3:0]  data_we;
        logic [3:0]  mway;
        logic [31:0] raddr;
        logic [31:0] rwdata;
        logic [15:0] hits;
        logic [15:0] misses;
        logic [15:0] wbs;
    } cyc_t;

    int unsigned n_chk = 0;
    int unsigned n_pass = 0;
    int unsigned cyc = 0;

    // Reference model state
    logic        err_m = 1'b0;
    logic [31:0] last_addr = '0;
    logic [31:0] last_wdata = '0;
    logic [15:0] hit_m = '0, miss_m = '0, wb_m = '0;

    cyc_t exp_c;
    logic exp_valid = 1'b0;

    // Per-transaction observations used by the literal checks
    int unsigned acc_cyc, rsp_cyc, mreq_n, mwe_n;
    logic [3:0]  last_lru, last_dwe, last_twe;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] want);
        n_chk++;
        if (act === want) n_pass++;
        else $display("FAIL %s cycle %0d: got %0h, expected %0h", name, cyc, act, want);
    endfunction

    function automatic logic [3:0] lowest(input logic [3:0] v);
        for (int i = 0; i < 4; i++) begin
            if (v[i]) return 4'(1 << i);
        end
        return 4'd0;
    endfunction

    // A cycle in which the controller is busy: every input except mem_ack is
    // noise that the controller must ignore.
    function automatic cyc_t busy_rec();
        cyc_t c;
        c = '0;
        c.req    = 1'($urandom);
        c.we     = 1'($urandom);
        c.addr   = $urandom;
        c.wdata  = $urandom;
        c.wh     = 4'($urandom);
        c.fov    = 4'($urandom);
        c.dirty  = 1'($urandom);
        c.err    = err_m;
        c.raddr  = last_addr;
        c.rwdata = last_wdata;
        c.hits   = hit_m;
        c.misses = miss_m;
        c.wbs    = wb_m;
        return c;
    endfunction

    function automatic cyc_t idle_rec();
        cyc_t c;
        c = busy_rec();
        c.req   = 1'b0;
        c.ready = 1'b1;
        c.ack   = 1'($urandom);
        return c;
    endfunction

    function automatic cyc_t lookup_rec(input logic we, input logic [3:0] wh);
        cyc_t c;
        c = busy_rec();
        c.wh     = wh;
        c.ack    = 1'($urandom);
        c.access = 1'b1;
        if (wh != 4'd0) begin
            c.lru_we  = 1'b1;
            c.lru_way = lowest(wh);
            if (we) begin
                c.data_we = lowest(wh);
                c.mod_set = 1'b1;
            end
        end
        return c;
    endfunction

    function automatic cyc_t mem_rec(input logic [3:0] victim, input logic is_wb,
                                     input logic last);
        cyc_t c;
        c = busy_rec();
        c.mreq = 1'b1;
        c.mwe  = is_wb;
        c.mway = victim;
        c.ack  = last;
        if (!is_wb && last) begin
            c.tag_we  = victim;
            c.data_we = victim;
            c.val_set = 1'b1;
            c.mod_clr = 1'b1;
        end
        return c;
    endfunction

    task automatic drive(input cyc_t c);
        pe_req             = c.req;
        pe_we              = c.we;
        pe_addr            = c.addr;
        pe_wdata           = c.wdata;
        way_hit            = c.wh;
        fill_or_victim_way = c.fov;
        victim_dirty       = c.dirty;
        mem_ack            = c.ack;
    endtask

    task automatic step(input cyc_t c);
        drive(c);
        exp_c     = c;
        exp_valid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // The single compare process: every output, every cycle, against the table.
    always @(negedge clk) begin
        if (exp_valid) begin
            chk("pe_ready", 32'(pe_ready), 32'(exp_c.ready));
            chk("pe_rsp_valid", 32'(pe_rsp_valid), 32'(exp_c.rsp));
            chk("pe_access", 32'(pe_access), 32'(exp_c.access));
            chk("req_addr", req_addr, exp_c.raddr);
            chk("req_wdata", req_wdata, exp_c.rwdata);
            chk("lru_we", 32'(lru_we), 32'(exp_c.lru_we));
            chk("lru_way", 32'(lru_way), 32'(exp_c.lru_way));
            chk("data_we", 32'(data_we), 32'(exp_c.data_we));
            chk("tag_we", 32'(tag_we), 32'(exp_c.tag_we));
            chk("mod_set", 32'(mod_set), 32'(exp_c.mod_set));
            chk("val_set", 32'(val_set), 32'(exp_c.val_set));
            chk("mod_clr", 32'(mod_clr), 32'(exp_c.mod_clr));
            chk("mem_req", 32'(mem_req), 32'(exp_c.mreq));
            chk("mem_we", 32'(mem_we), 32'(exp_c.mwe));
            chk("mem_way", 32'(mem_way), 32'(exp_c.mway));
            chk("ctrl_err", 32'(ctrl_err), 32'(exp_c.err));
`ifdef CACHE_CTRL_PERF_CNT_EN
            chk("hit_cnt", 32'(hit_cnt), 32'(exp_c.hits));
            chk("miss_cnt", 32'(miss_cnt), 32'(exp_c.misses));
            chk("wb_cnt", 32'(wb_cnt), 32'(exp_c.wbs));
`endif
            if (pe_rsp_valid) rsp_cyc = cyc;
            if (mem_req) mreq_n++;
            if (mem_req && mem_we) mwe_n++;
            if (lru_we) last_lru = lru_way;
            if (data_we != 4'd0) last_dwe = data_we;
            if (tag_we != 4'd0) last_twe = tag_we;
        end
    end

    // Expand one transaction into its cycles, as the controller's rules
    // dictate, and play it.
    task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] wh1, input logic [3:0] victim,
                           input logic dirty, input int wb_n, input int fill_n,
                           input logic [3:0] wh2);
        cyc_t c;
        acc_cyc  = cyc;
        rsp_cyc  = 0;
        mreq_n   = 0;
        mwe_n    = 0;
        last_lru = '0;
        last_dwe = '0;
        last_twe = '0;

        c = idle_rec();
        c.req   = 1'b1;
        c.we    = we;
        c.addr  = addr;
        c.wdata = wdata;
        step(c);
        last_addr  = addr;
        last_wdata = wdata;

        c = lookup_rec(we, wh1);
        c.fov   = victim;
        c.dirty = dirty;
        step(c);
        if ($countones(wh1) > 1) err_m = 1'b1;
        if (wh1 != 4'd0) begin
            if (hit_m != 16'hffff) hit_m++;
        end else begin
            if (miss_m != 16'hffff) miss_m++;
            if (dirty) begin
                for (int i = 0; i < wb_n; i++) step(mem_rec(victim, 1'b1, i == wb_n - 1));
                if (wb_m != 16'hffff) wb_m++;
            end
            for (int i = 0; i < fill_n; i++) step(mem_rec(victim, 1'b0, i == fill_n - 1));
            step(lookup_rec(we, wh2));
            if (wh2 == 4'd0 || $countones(wh2) > 1) err_m = 1'b1;
        end

        c = busy_rec();
        c.rsp = 1'b1;
        step(c);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_pe_ready"}, 32'(pe_ready), 32'd1);
        chk({tag, "_pe_rsp_valid"}, 32'(pe_rsp_valid), 32'd0);
        chk({tag, "_pe_access"}, 32'(pe_access), 32'd0);
        chk({tag, "_mem_req"}, 32'(mem_req), 32'd0);
        chk({tag, "_mem_way"}, 32'(mem_way), 32'd0);
        chk({tag, "_req_addr"}, req_addr, 32'd0);
        chk({tag, "_strobes"}, {lru_we, val_set, mod_set, mod_clr, mem_we,
                                lru_way, tag_we, data_we}, 32'd0);
        chk({tag, "_ctrl_err"}, 32'(ctrl_err), 32'd0);
`ifdef CACHE_CTRL_PERF_CNT_EN
        chk({tag, "_counters"}, 32'(hit_cnt | miss_cnt | wb_cnt), 32'd0);
`endif
    endtask

    task automatic model_reset();
        err_m      = 1'b0;
        last_addr  = '0;
        last_wdata = '0;
        hit_m      = '0;
        miss_m     = '0;
        wb_m       = '0;
    endtask

    initial begin
        cyc_t c;
        logic [3:0] v;
        logic [3:0] wh;

        #12;
        check_reset_vals("reset");
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Read hit in way 2
        run_txn(1'b0, 32'h0000_1000, 32'h0, 4'b0100, 4'b0001, 1'b0, 1, 1, 4'b0);
        chk("rd_hit_latency", rsp_cyc - acc_cyc, 32'd2);
        chk("rd_hit_lru_way", 32'(last_lru), 32'b0100);
        chk("rd_hit_no_mem", mreq_n, 32'd0);

        // Write hit in way 0
        run_txn(1'b1, 32'h0000_2004, 32'hcafe_f00d, 4'b0001, 4'b0010, 1'b1, 1, 1, 4'b0);
        chk("wr_hit_data_we", 32'(last_dwe), 32'b0001);
        chk("wr_hit_latency", rsp_cyc - acc_cyc, 32'd2);

        // Clean miss, victim way 3, fill acked on its third cycle
        run_txn(1'b0, 32'h0000_3008, 32'h0, 4'b0000, 4'b1000, 1'b0, 1, 3, 4'b1000);
        chk("clean_miss_mem_cycles", mreq_n, 32'd3);
        chk("clean_miss_no_wb", mwe_n, 32'd0);
        chk("clean_miss_tag_we", 32'(last_twe), 32'b1000);
        chk("clean_miss_latency", rsp_cyc - acc_cyc, 32'd6);

        // Dirty miss, victim way 1, writeback then fill, two cycles each
        run_txn(1'b1, 32'h0000_400c, 32'h1234_5678, 4'b0000, 4'b0010, 1'b1, 2, 2, 4'b0010);
        chk("dirty_miss_wb_cycles", mwe_n, 32'd2);
        chk("dirty_miss_mem_cycles", mreq_n, 32'd4);
        chk("dirty_miss_latency", rsp_cyc - acc_cyc, 32'd7);
        chk("dirty_miss_replay_dwe", 32'(last_dwe), 32'b0010);
`ifdef CACHE_CTRL_PERF_CNT_EN
        chk("dirty_miss_wb_cnt", 32'(wb_cnt), 32'd1);
`endif

        // Multi-hit: lowest way wins, error becomes sticky
        chk("err_before_multi", 32'(ctrl_err), 32'd0);
        run_txn(1'b0, 32'h0000_5010, 32'h0, 4'b0110, 4'b0001, 1'b0, 1, 1, 4'b0);
        chk("multi_hit_lru_way", 32'(last_lru), 32'b0010);
        chk("multi_hit_err", 32'(ctrl_err), 32'd1);
        step(idle_rec());
        chk("multi_hit_err_sticky", 32'(ctrl_err), 32'd1);

        // Reset in the middle of a fill
        c = idle_rec();
        c.req  = 1'b1;
        c.addr = 32'h0000_6014;
        step(c);
        last_addr  = 32'h0000_6014;
        last_wdata = c.wdata;
        c = lookup_rec(1'b0, 4'b0000);
        c.fov   = 4'b0100;
        c.dirty = 1'b0;
        step(c);
        if (miss_m != 16'hffff) miss_m++;
        step(mem_rec(4'b0100, 1'b0, 1'b0));
        drive(mem_rec(4'b0100, 1'b0, 1'b0));
        exp_valid = 1'b0;
        chk("pre_reset_mem_req", 32'(mem_req), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_vals("mid_fill_reset");
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        rsp_cyc = 0;
        for (int i = 0; i < 4; i++) step(idle_rec());
        chk("no_rsp_after_reset", rsp_cyc, 32'd0);

        // Miss on replay: error flagged, response still issued
        chk("err_before_replay_miss", 32'(ctrl_err), 32'd0);
        run_txn(1'b1, 32'h0000_7018, 32'hdead_beef, 4'b0000, 4'b0001, 1'b0, 1, 1, 4'b0000);
        chk("replay_miss_latency", rsp_cyc - acc_cyc, 32'd4);
        chk("replay_miss_err", 32'(ctrl_err), 32'd1);

        // Clear the error again, then run randomized traffic
        exp_valid = 1'b0;
        reset_n   = 1'b0;
        #1;
        model_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int t = 0; t < 200; t++) begin
            int gap;
            gap = int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) step(idle_rec());
            v = 4'(1 << $urandom_range(0, 3));
            case ($urandom_range(0, 19))
                0:        wh = 4'($urandom) | 4'b0011;  // multi-hit
                1,2,3,4,5,6,7,8,9,10: wh = 4'(1 << $urandom_range(0, 3));
                default:  wh = 4'd0;
            endcase
            run_txn(1'($urandom), $urandom, $urandom, wh, v, 1'($urandom),
                    int'($urandom_range(1, 4)), int'($urandom_range(1, 4)),
                    ($urandom_range(0, 9) == 0) ? 4'd0 : v);
        end
        step(idle_rec());
        exp_valid = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
